// File: rtl/iexu_issue_scheduler.sv
// Integer-unit issue stage: result-bus reservation table plus divider busy tracking (optional IEXU_STALL_COUNTER_EN adds stall_count_o).
// One-cycle issue latency; issue_ready_o drops combinationally when the target unit's result slot or the divider is busy.
package iexu_issue_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [7:0]  tag;
  } instr_packet_t;

  typedef struct packed {
    logic [4:0] opc;
    logic       sub;
    logic       sgn;
  } iexu_uop_t;

  localparam logic [3:0] UNIT_ALU = 4'b0001;
  localparam logic [3:0] UNIT_BMU = 4'b0010;
  localparam logic [3:0] UNIT_MUL = 4'b0100;
  localparam logic [3:0] UNIT_DIV = 4'b1000;

endpackage

module iexu_issue_scheduler
  import iexu_issue_pkg::*;
#(
  parameter int MUL_LATENCY = 4,
  parameter int DIV_LATENCY = 34,
  parameter int DEPTH       = DIV_LATENCY + 2
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          clk_en_i,
  input  logic          flush_i,
  input  logic          issue_valid_i,
  input  logic [3:0]    issue_unit_i,
  output logic          issue_ready_o,
  input  instr_packet_t ipacket_i,
  input  iexu_uop_t     operation_i,
  input  logic [31:0]   operand_1_i,
  input  logic [31:0]   operand_2_i,
  input  logic          div_idle_i,
  output instr_packet_t ipacket_o,
  output iexu_uop_t     operation_o,
  output logic [31:0]   operand_1_o,
  output logic [31:0]   operand_2_o,
  output logic [3:0]    data_valid_o,
  output logic          stall_o
`ifdef IEXU_STALL_COUNTER_EN
  ,
  output logic [31:0]   stall_count_o
`endif
);

  localparam int CNT_W = $clog2(DIV_LATENCY + 2);

  logic [DEPTH-1:0] res_q;
  logic [CNT_W-1:0] div_cnt_q;
  logic [DEPTH-1:0] slot_mask;
  logic [DEPTH-1:0] grant_mask;
  logic             unit_onehot;
  logic             unit_ok;
  logic             grant;

  assign unit_onehot = (issue_unit_i != 4'd0) &&
                       ((issue_unit_i & (issue_unit_i - 4'd1)) == 4'd0);

  // Slot checked is latency+1: the op reaches the integer unit one cycle after the grant.
  always_comb begin
    slot_mask = '0;
    unit_ok   = 1'b1;
    case (issue_unit_i)
      UNIT_ALU: slot_mask = DEPTH'(1) << 1;
      UNIT_BMU: slot_mask = DEPTH'(1) << 2;
      UNIT_MUL: slot_mask = DEPTH'(1) << (MUL_LATENCY + 1);
      UNIT_DIV: begin
        slot_mask = DEPTH'(1) << (DIV_LATENCY + 1);
        unit_ok   = div_idle_i && (div_cnt_q == '0);
      end
      default: unit_ok = 1'b0;
    endcase
  end

  assign grant         = issue_valid_i && clk_en_i && !flush_i && unit_onehot &&
                         unit_ok && ((res_q & slot_mask) == '0);
  assign grant_mask    = grant ? slot_mask : '0;
  assign issue_ready_o = grant;
  assign stall_o       = issue_valid_i && !issue_ready_o;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      res_q        <= '0;
      div_cnt_q    <= '0;
      data_valid_o <= 4'd0;
    end else if (clk_en_i) begin
      // Reservations keep shifting under flush: the units still finish in-flight work.
      res_q        <= (res_q | grant_mask) >> 1;
      data_valid_o <= grant ? issue_unit_i : 4'd0;
      if (grant && (issue_unit_i == UNIT_DIV)) begin
        div_cnt_q <= CNT_W'(DIV_LATENCY + 1);
      end else if (div_cnt_q != '0) begin
        div_cnt_q <= div_cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ipacket_o   <= '0;
      operation_o <= '0;
      operand_1_o <= 32'd0;
      operand_2_o <= 32'd0;
    end else if (grant) begin
      ipacket_o   <= ipacket_i;
      operation_o <= operation_i;
      operand_1_o <= operand_1_i;
      operand_2_o <= operand_2_i;
    end
  end

`ifdef IEXU_STALL_COUNTER_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_count_o <= 32'd0;
    end else if (clk_en_i) begin
      if (flush_i) begin
        stall_count_o <= 32'd0;
      end else if (stall_o && (stall_count_o != 32'hFFFF_FFFF)) begin
        stall_count_o <= stall_count_o + 32'd1;
      end
    end
  end
`endif

endmodule
